alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Result-capture stage directly downstream of the multi-lane ALU. Samples the ALU result bus, carry, compare flags and opcode on each `enable` strobe and queues them in a small first-word-fall-through FIFO. Presents them to the consumer (scoreboard or writeback) through a valid/ready handshake. Overflow is flagged, never silent.

## Interface

**Parameters**
- `WIDTH`, 4, bit width of one ALU lane operand.
- `N_ALU`, 4, number of ALU lanes.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

**Ports**
- `clk` in 1: single clock, rising edge.
- `arst` in 1: reset; asynchronous assert, active-low; release synchronous to `clk` by integration.
- `enable` in 1: push strobe from ALU stage; one result per cycle while high.
- `select` in 3: ALU opcode of the result being pushed.
- `alu_out` in `WIDTH*N_ALU*8`: ALU result bus.
- `carry_out` in 1: ALU carry.
- `a_greater`, `a_equal`, `a_less` in 1 each: ALU compare flags.
- `res_valid` out 1: head entry available.
- `res_ready` in 1: consumer accepts head this cycle.
- `res_data` out `WIDTH*N_ALU*8`: head result.
- `res_sel` out 3: head opcode.
- `res_carry` out 1: head carry.
- `res_flags` out 3: head `{a_greater, a_equal, a_less}`.
- `full` out 1: count == `DEPTH`.
- `empty` out 1: count == 0.
- `count` out `$clog2(DEPTH)+1`: occupancy.
- `overflow` out 1: sticky; set on dropped push.
- `flag_err` out 1: sticky; set when a push carries a compare-flag triple that is not one-hot.

## Operation

- **Storage:** `DEPTH` entries, each `{alu_out, select, carry_out, a_greater, a_equal, a_less}`.
- **Pointers:**
  - Write pointer and read pointer, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
  - `count` is a separate register.
- **Push accepted:** `enable && (!full || pop)`, where `pop = res_valid && res_ready`. Entry is written at wptr, and wptr increments.
- **Push dropped:** `enable && full && !pop`. Storage is unchanged and `overflow` is set. `overflow` is cleared only by reset.
- **Pop:** `res_valid && res_ready` advances rptr. `res_ready` while empty is ignored.
- **Simultaneous push and pop:**
  - `count` is unchanged.
  - This is legal at full, where it frees and refills a slot in the same edge.
  - At empty, no pop occurs (`res_valid` is 0). Only the push takes effect.
- **`count` update:** +1 on push-only, −1 on pop-only, unchanged otherwise. It never exceeds `DEPTH` or goes below 0.
- **Head outputs:** `res_*` are driven combinationally from entry[rptr] (FWFT). When empty, the values are don't-care, but the bench shall not check them.
- **`flag_err`:** set when an accepted push has `{a_greater,a_equal,a_less}` not one-hot. Data is still stored.
- **Reset (`arst` low, any time):**
  - Pointers, `count`, `overflow`, `flag_err` cleared immediately.
  - Outputs: `res_valid`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `flag_err`=0.
  - Storage contents are not reset.
  - Reset mid-operation discards all queued entries.

## Timing

- **Push latency:** a push sampled at edge N gives `res_valid`=1 and valid `res_*` after edge N when the FIFO was empty. Latency is 1 cycle, with no combinational path from `enable` to `res_valid`.
- **Pop:** takes effect at the edge where `res_valid && res_ready`. The next head appears after that edge.
- **Throughput:** one push and one pop per cycle, sustained.
- **Registered flags:** `full`, `empty`, `count`, `overflow`, `flag_err` are registered and update after the causing edge.
- **Ready path:** `res_ready` may depend combinationally on `res_valid`. The block must not create a loop from `res_ready` to `res_valid`.

## Configuration

- **Macro:** `ALU_RESULT_FIFO_STATS_EN`.
- **Defined:** adds outputs `push_cnt` (16 bits, counts accepted pushes) and `drop_cnt` (16 bits, counts dropped pushes).
  - Both saturate at `16'hFFFF` and do not wrap.
  - Both reset to 0 on `arst`.
- **Undefined:** these ports and counters do not exist. All other behaviour is identical.

## Test plan

- **Reset:** hold `arst`=0 for 3 cycles, then release. Expect `empty`=1, `count`=0, `res_valid`=0, `overflow`=0 throughout.
- **Single transfer:** with `res_ready`=0, push one entry (`alu_out`=`128'h1234`, `select`=3'd2, `carry_out`=1, flags=3'b100). Expect `res_valid`=1 one cycle later with the same values and `count`=1. Then raise `res_ready` for 1 cycle; expect `empty`=1.
- **Fill and overflow:** with `res_ready`=0, push 5 consecutive values 1..5 at `DEPTH`=4.
  - Expect `full`=1 after the 4th push.
  - Expect the 5th push dropped, with `overflow`=1 (and `drop_cnt`=1 if STATS).
  - Drain with `res_ready`=1; expect 1,2,3,4 in order.
- **Full with simultaneous push/pop:** at full, assert `enable` and `res_ready` together for 8 cycles. Expect `count`=4 throughout, no overflow, and output order preserved (values 1..12 stream out in order).
- **Flag check:** push with flags=3'b110. Expect `flag_err`=1 next cycle, with data still stored and `res_flags`=3'b110.
- **Reset mid-stream:** with `count`=3, pulse `arst` low asynchronously between edges. Expect `count`=0, `res_valid`=0 and `overflow`=0 immediately. A subsequent push of value 7 is delivered first.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT queue capturing ALU results behind a valid/ready port.
// Optional push/drop statistics counters under ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int N_ALU = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       enable,
  input  logic [2:0]                 select,
  input  logic [WIDTH*N_ALU*8-1:0]   alu_out,
  input  logic                       carry_out,
  input  logic                       a_greater,
  input  logic                       a_equal,
  input  logic                       a_less,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH*N_ALU*8-1:0]   res_data,
  output logic [2:0]                 res_sel,
  output logic                       res_carry,
  output logic [2:0]                 res_flags,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       flag_err
`ifdef ALU_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]                push_cnt,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int DW = WIDTH * N_ALU * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [AW-1:0] P_ONE  = AW'(1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    sel;
    logic          carry;
    logic [2:0]    flags;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_ferr;

  logic [2:0]    w_flags;
  logic          w_onehot;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_cnt_nxt;
  ent_t          w_in;
  ent_t          w_head;

  assign w_flags  = {a_greater, a_equal, a_less};
  assign w_onehot = (w_flags == 3'b100) |
                    (w_flags == 3'b010) |
                    (w_flags == 3'b001);

  // res_valid comes only from the registered empty flag, so res_ready
  // can never loop back into it.
  assign w_pop  = ~r_empty & res_ready;
  assign w_push = enable & (~r_full | w_pop);
  assign w_drop = enable & r_full & ~w_pop;

  assign w_in = '{data:  alu_out,
                  sel:   select,
                  carry: carry_out,
                  flags: w_flags};

  // Occupancy for the next edge: push-only adds, pop-only subtracts.
  always_comb begin
    w_cnt_nxt = r_count;
    unique case (1'b1)
      (w_push & ~w_pop): w_cnt_nxt = r_count + C_ONE;
      (w_pop & ~w_push): w_cnt_nxt = r_count - C_ONE;
      default:           w_cnt_nxt = r_count;
    endcase
  end

  // Pointers, occupancy, registered status and sticky error flags.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + P_ONE;
      if (w_pop)  r_rptr <= r_rptr + P_ONE;
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == C_FULL);
      r_empty <= (w_cnt_nxt == '0);
      if (w_drop) r_ovf <= 1'b1;
      if (w_push && !w_onehot) r_ferr <= 1'b1;
    end
  end

  // Entry storage; contents survive reset, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in;
  end

  assign w_head    = r_mem[r_rptr];
  assign res_valid = ~r_empty;
  assign res_data  = w_head.data;
  assign res_sel   = w_head.sel;
  assign res_carry = w_head.carry;
  assign res_flags = w_head.flags;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign flag_err  = r_ferr;

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0] r_push_cnt;
  logic [15:0] r_drop_cnt;

  // Saturating counters of accepted and dropped pushes.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_push_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push && r_push_cnt != 16'hFFFF)
        r_push_cnt <= r_push_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign push_cnt = r_push_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scoreboard bench for alu_result_fifo.
// Expected heads are queued on push and compared when popped.
module tb_alu_result_fifo;

  localparam int DW = 128;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [2:0]    s;
    logic          c;
    logic [2:0]    f;
  } ent_t;

  logic          clk = 1'b0;
  logic          arst;
  logic          enable;
  logic [2:0]    select;
  logic [DW-1:0] alu_out;
  logic          carry_out;
  logic          a_greater;
  logic          a_equal;
  logic          a_less;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [2:0]    res_sel;
  logic          res_carry;
  logic [2:0]    res_flags;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          overflow;
  logic          flag_err;
`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [15:0]   push_cnt;
  logic [15:0]   drop_cnt;
`endif

  ent_t q[$];
  ent_t e;
  ent_t head;
  int   total = 0;
  int   bad   = 0;

  assign head = {res_data, res_sel, res_carry, res_flags};

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(4), .N_ALU(4), .DEPTH(4)) dut (
    .clk       (clk),
    .arst      (arst),
    .enable    (enable),
    .select    (select),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .a_greater (a_greater),
    .a_equal   (a_equal),
    .a_less    (a_less),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_sel   (res_sel),
    .res_carry (res_carry),
    .res_flags (res_flags),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .flag_err  (flag_err)
`ifdef ALU_RESULT_FIFO_STATS_EN
    ,
    .push_cnt  (push_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic drive(input ent_t x);
    enable    = 1'b1;
    alu_out   = x.d;
    select    = x.s;
    carry_out = x.c;
    {a_greater, a_equal, a_less} = x.f;
  endtask

  function automatic ent_t mk(input int v);
    ent_t r;
    r.d = DW'(v) | (DW'(v) << 100);
    r.s = 3'(v);
    r.c = v[0];
    r.f = (v % 3 == 0) ? 3'b100 : (v % 3 == 1) ? 3'b010 : 3'b001;
    return r;
  endfunction

  task automatic test_reset;
    arst = 1'b0;
    enable = 1'b0;
    res_ready = 1'b0;
    drive(mk(0));
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({empty, count, res_valid, overflow, flag_err, full} !== 8'b1_000_0000) begin
        bad++;
        $display("FAIL reset_hold got=%b exp=%b",
          {empty, count, res_valid, overflow, flag_err, full}, 8'b1_000_0000);
      end
    end
    arst = 1'b1;
    @(negedge clk);
    total++;
    if ({empty, count, res_valid, overflow} !== 6'b1_000_0_0) begin
      bad++;
      $display("FAIL reset_release got=%b exp=%b",
        {empty, count, res_valid, overflow}, 6'b100000);
    end
  endtask

  task automatic test_single;
    e.d = 128'h1234; e.s = 3'd2; e.c = 1'b1; e.f = 3'b100;
    @(negedge clk);
    drive(e);
    q.push_back(e);
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (res_valid !== 1'b1 || count !== 3'd1) begin
      bad++;
      $display("FAIL single_valid got=%b/%0d exp=1/1", res_valid, count);
    end
    res_ready = 1'b1;
    e = q.pop_front();
    total++;
    if (head !== e) begin
      bad++;
      $display("FAIL single_head got=%h exp=%h", head, e);
    end
    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if (empty !== 1'b1 || count !== 3'd0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_empty got=%b/%0d exp=1/0", empty, count);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(mk(i));
      q.push_back(mk(i));
    end
    for (int i = 5; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL b2b_count i=%0d got=%0d/%b/%b exp=4/1/0",
          i, count, full, overflow);
      end
      drive(mk(i));
      res_ready = 1'b1;
      e = q.pop_front();
      total++;
      if (res_valid !== 1'b1 || head !== e) begin
        bad++;
        $display("FAIL b2b_head i=%0d got=%h exp=%h", i, head, e);
      end
      q.push_back(mk(i));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      enable = 1'b0;
      e = q.pop_front();
      total++;
      if (res_valid !== 1'b1 || head !== e) begin
        bad++;
        $display("FAIL b2b_drain k=%0d got=%h exp=%h", k, head, e);
      end
    end
    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%b/%b exp=1/0", empty, overflow);
    end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      total++;
      if (count !== 3'(i - 1)) begin
        bad++;
        $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i - 1);
      end
      drive(mk(i));
      if (i <= 4) q.push_back(mk(i));
    end
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL fill_ovf got=%b/%0d/%b exp=1/4/1", full, count, overflow);
    end
`ifdef ALU_RESULT_FIFO_STATS_EN
    total++;
    if (drop_cnt !== 16'd1 || push_cnt !== 16'd17) begin
      bad++;
      $display("FAIL stats got=%0d/%0d exp=1/17", drop_cnt, push_cnt);
    end
`endif
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = q.pop_front();
      total++;
      if (res_valid !== 1'b1 || head !== e) begin
        bad++;
        $display("FAIL fill_drain k=%0d got=%h exp=%h", k, head, e);
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    total++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL fill_end got=%b/%b exp=1/1", empty, overflow);
    end
  endtask

  task automatic test_flag;
    e.d = 128'hABC; e.s = 3'd5; e.c = 1'b0; e.f = 3'b110;
    total++;
    if (flag_err !== 1'b0) begin
      bad++;
      $display("FAIL flag_pre got=%b exp=0", flag_err);
    end
    drive(e);
    q.push_back(e);
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (flag_err !== 1'b1 || res_flags !== 3'b110) begin
      bad++;
      $display("FAIL flag_err got=%b/%b exp=1/110", flag_err, res_flags);
    end
    res_ready = 1'b1;
    e = q.pop_front();
    total++;
    if (res_valid !== 1'b1 || head !== e) begin
      bad++;
      $display("FAIL flag_head got=%h exp=%h", head, e);
    end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive(mk(i + 20));
      q.push_back(mk(i + 20));
    end
    @(negedge clk);
    enable = 1'b0;
    total++;
    if (count !== 3'd3) begin
      bad++;
      $display("FAIL mid_pre got=%0d exp=3", count);
    end
    #2;
    arst = 1'b0;
    #1;
    q.delete();
    total++;
    if ({count, res_valid, overflow, flag_err, empty} !== 7'b000_0001) begin
      bad++;
      $display("FAIL mid_async got=%b exp=%b",
        {count, res_valid, overflow, flag_err, empty}, 7'b0000001);
    end
    #1;
    arst = 1'b1;
    @(negedge clk);
    e = mk(7);
    drive(e);
    q.push_back(e);
    @(negedge clk);
    enable = 1'b0;
    res_ready = 1'b1;
    e = q.pop_front();
    total++;
    if (res_valid !== 1'b1 || count !== 3'd1 || head !== e) begin
      bad++;
      $display("FAIL mid_first got=%h exp=%h", head, e);
    end
    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL mid_end got=%b exp=1", empty);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_fill_overflow;
    test_flag;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
